// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and types for the ALU front-end sequencer: ALU control codes,
// MIPS opcode/funct encodings, sequencer states and op classes.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only ARITH reports overflow; set-less-than lives in LOGIC so slt/slti never do.
    typedef enum logic [1:0] {
        CLS_ARITH  = 2'd0,
        CLS_LOGIC  = 2'd1,
        CLS_BRANCH = 2'd2,
        CLS_MEM    = 2'd3
    } op_class_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Upstream instruction handshake and downstream result handshake of the sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [15:0]       imm;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic              res_ovf;
    logic              res_branch;
    logic              res_illegal;

    modport master (
        output in_valid, opcode, funct, rs_val, rt_val, imm, out_ready,
        input  in_ready, out_valid, res_data, res_zero, res_ovf, res_branch, res_illegal
    );

    modport slave (
        input  in_valid, opcode, funct, rs_val, rt_val, imm, out_ready,
        output in_ready, out_valid, res_data, res_zero, res_ovf, res_branch, res_illegal
    );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational instruction decode: opcode/funct to ALU control, operand-b source,
// immediate extension mode, op class and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       b_imm,
    output logic       zero_ext,
    output op_class_t  op_class,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_AND;
        b_imm       = 1'b0;
        zero_ext    = 1'b0;
        op_class    = CLS_LOGIC;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_AND: alu_control = ALU_AND;
                    FN_OR:  alu_control = ALU_OR;
                    FN_NOR: alu_control = ALU_NOR;
                    FN_SLT: alu_control = ALU_SLT;
                    FN_ADD: begin
                        alu_control = ALU_ADD;
                        op_class    = CLS_ARITH;
                    end
                    FN_SUB: begin
                        alu_control = ALU_SUB;
                        op_class    = CLS_ARITH;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_control = ALU_ADD;
                b_imm       = 1'b1;
                op_class    = CLS_ARITH;
            end
            OP_LW, OP_SW: begin
                alu_control = ALU_ADD;
                b_imm       = 1'b1;
                op_class    = CLS_MEM;
            end
            OP_SLTI: begin
                alu_control = ALU_SLT;
                b_imm       = 1'b1;
            end
            OP_ANDI: begin
                alu_control = ALU_AND;
                b_imm       = 1'b1;
                zero_ext    = 1'b1;
            end
            OP_ORI: begin
                alu_control = ALU_OR;
                b_imm       = 1'b1;
                zero_ext    = 1'b1;
            end
            OP_BEQ: begin
                alu_control = ALU_SUB;
                op_class    = CLS_BRANCH;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle ALU front end: accepts a decoded instruction, drives alu_32 for
// EXEC_CYCLES cycles, captures result/flags and offers them downstream.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        exec_cnt;
    op_class_t         op_class_q;

    logic [3:0]        dec_control;
    logic              dec_b_imm;
    logic              dec_zero_ext;
    op_class_t         dec_class;
    logic              dec_illegal;
    logic [DATA_W-1:0] imm_ext;

    alu_op_decode u_decode (
        .opcode      (bus.opcode),
        .funct       (bus.funct),
        .alu_control (dec_control),
        .b_imm       (dec_b_imm),
        .zero_ext    (dec_zero_ext),
        .op_class    (dec_class),
        .illegal     (dec_illegal)
    );

    assign imm_ext = dec_zero_ext ? {{(DATA_W-16){1'b0}}, bus.imm}
                                  : {{(DATA_W-16){bus.imm[15]}}, bus.imm};

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = dec_illegal ? ST_DONE : ST_EXEC;
            ST_EXEC: if (exec_cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            exec_cnt        <= 4'd0;
            op_class_q      <= CLS_ARITH;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_control     <= ALU_AND;
            bus.res_data    <= '0;
            bus.res_zero    <= 1'b0;
            bus.res_ovf     <= 1'b0;
            bus.res_branch  <= 1'b0;
            bus.res_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        bus.res_data    <= '0;
                        bus.res_zero    <= 1'b0;
                        bus.res_ovf     <= 1'b0;
                        bus.res_branch  <= 1'b0;
                        bus.res_illegal <= dec_illegal;
                        // Illegal encodings leave the ALU operands untouched.
                        if (!dec_illegal) begin
                            alu_a       <= bus.rs_val;
                            alu_b       <= dec_b_imm ? imm_ext : bus.rt_val;
                            alu_control <= dec_control;
                            op_class_q  <= dec_class;
                            exec_cnt    <= EXEC_LOAD;
                        end
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        bus.res_data   <= alu_result;
                        bus.res_zero   <= alu_zero;
                        bus.res_ovf    <= (op_class_q == CLS_ARITH) && alu_overflow;
                        bus.res_branch <= (op_class_q == CLS_BRANCH) && alu_zero;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer with a behavioural alu_32
// stand-in and an instruction-level reference model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DATA_W      = 32;
    localparam int EXEC_CYCLES = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer_if #(.DATA_W(DATA_W)) bus ();

    alu_op_sequencer #(.DATA_W(DATA_W), .EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural alu_32: overflow reflects the adder for ADD and the subtractor for SUB/SLT.
    always_comb begin
        logic [31:0] diff;
        diff         = alu_a - alu_b;
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            4'b0010: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'b0110: begin
                alu_result   = diff;
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            4'b0111: begin
                alu_result   = {31'd0, $signed(alu_a) < $signed(alu_b)};
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            default: ;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct packed {
        logic        ill;
        logic [3:0]  ctl;
        logic [31:0] data;
        logic        zero;
        logic        ovf;
        logic        br;
    } exp_t;

    localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_SLT = 3, K_AND = 4, K_OR = 5, K_NOR = 6;

    function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [15:0] im);
        exp_t        e;
        int          kind;
        logic [31:0] b;
        logic [32:0] wide;
        logic        ovf_ok;
        logic        is_beq;
        e = '0;
        b = rt;
        kind = K_ILL;
        ovf_ok = 1'b0;
        is_beq = 1'b0;
        if (op == 6'd0) begin
            if (fn == 6'd32)      begin kind = K_ADD; ovf_ok = 1'b1; end
            else if (fn == 6'd34) begin kind = K_SUB; ovf_ok = 1'b1; end
            else if (fn == 6'd36) kind = K_AND;
            else if (fn == 6'd37) kind = K_OR;
            else if (fn == 6'd39) kind = K_NOR;
            else if (fn == 6'd42) kind = K_SLT;
        end else if (op == 6'd8) begin
            kind = K_ADD; ovf_ok = 1'b1; b = 32'($signed(im));
        end else if (op == 6'd35 || op == 6'd43) begin
            kind = K_ADD; b = 32'($signed(im));
        end else if (op == 6'd10) begin
            kind = K_SLT; b = 32'($signed(im));
        end else if (op == 6'd12) begin
            kind = K_AND; b = {16'd0, im};
        end else if (op == 6'd13) begin
            kind = K_OR; b = {16'd0, im};
        end else if (op == 6'd4) begin
            kind = K_SUB; is_beq = 1'b1;
        end
        case (kind)
            K_ADD: begin
                e.ctl  = 4'b0010;
                e.data = rs + b;
                wide   = 33'($signed(rs)) + 33'($signed(b));
                e.ovf  = ovf_ok && (wide[32] != wide[31]);
            end
            K_SUB: begin
                e.ctl  = 4'b0110;
                e.data = rs - b;
                wide   = 33'($signed(rs)) - 33'($signed(b));
                e.ovf  = ovf_ok && (wide[32] != wide[31]);
            end
            K_SLT: begin e.ctl = 4'b0111; e.data = ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0; end
            K_AND: begin e.ctl = 4'b0000; e.data = rs & b; end
            K_OR:  begin e.ctl = 4'b0001; e.data = rs | b; end
            K_NOR: begin e.ctl = 4'b1100; e.data = ~(rs | b); end
            default: e.ill = 1'b1;
        endcase
        if (!e.ill) begin
            e.zero = (e.data == 32'd0);
            e.br   = is_beq && e.zero;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input exp_t e);
        chk({tag, "_data"},    bus.res_data, e.data);
        chk({tag, "_zero"},    32'(bus.res_zero), 32'(e.zero));
        chk({tag, "_ovf"},     32'(bus.res_ovf), 32'(e.ovf));
        chk({tag, "_branch"},  32'(bus.res_branch), 32'(e.br));
        chk({tag, "_illegal"}, 32'(bus.res_illegal), 32'(e.ill));
    endtask

    task automatic txn(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im, input int bp);
        exp_t e;
        int   n;
        e = ref_model(op, fn, rs, rt, im);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.imm      = im;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.opcode   = 6'($urandom);
        bus.rs_val   = $urandom;
        n = 1;
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (!e.ill) chk("alu_control", 32'(alu_control), 32'(e.ctl));
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), e.ill ? 32'd1 : 32'(1 + EXEC_CYCLES));
        chk_res("res", e);
        // Offer a new instruction while DONE: it must be ignored, also on the handshake edge.
        bus.in_valid = 1'b1;
        bus.opcode   = OP_RTYPE;
        bus.funct    = FN_ADD;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk_res("hold", e);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    logic [5:0] op_pool [10] = '{OP_RTYPE, OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_SLTI,
                                 OP_ANDI, OP_ORI, OP_BEQ, 6'b000010};
    logic [5:0] fn_pool [8]  = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT,
                                 6'b000000, 6'b100001};

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rop;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.rs_val    = '0;
        bus.rt_val    = '0;
        bus.imm       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_illegal", 32'(bus.res_illegal), 32'd0);

        txn(OP_RTYPE, FN_ADD, 32'd100, 32'd50, 16'd0, 0);
        chk("add_150", bus.res_data, 32'd150);
        txn(OP_RTYPE, FN_SUB, 32'h8000_0000, 32'd1, 16'd0, 1);
        txn(OP_SLTI, 6'd0, 32'h8000_0000, 32'd0, 16'd1, 0);
        txn(OP_BEQ, 6'd0, 32'd200, 32'd200, 16'd0, 0);
        txn(OP_BEQ, 6'd0, 32'd200, 32'd150, 16'd0, 0);
        txn(OP_ADDI, 6'd0, 32'd0, 32'd0, 16'hFFFF, 0);
        txn(OP_ORI, 6'd0, 32'd0, 32'd0, 16'hFFFF, 0);
        txn(6'b111111, 6'd0, 32'd5, 32'd6, 16'd7, 0);
        txn(OP_RTYPE, FN_NOR, 32'h0F0F_0000, 32'h0000_00FF, 16'd0, 5);
        txn(OP_ADDI, 6'd0, 32'h7FFF_FFFF, 32'd0, 16'd1, 0);
        txn(OP_LW, 6'd0, 32'h7FFF_FFFF, 32'd0, 16'd1, 0);

        // Reset while in EXEC discards the transaction.
        @(negedge clk);
        bus.opcode   = OP_RTYPE;
        bus.funct    = FN_SUB;
        bus.rs_val   = 32'd9;
        bus.rt_val   = 32'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_rst_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_alu_control", 32'(alu_control), 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_res_data", bus.res_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);
        end

        for (int t = 0; t < 40; t++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rop = op_pool[$urandom_range(0, 9)];
            txn(rop, fn_pool[$urandom_range(0, 7)], ra, rb, 16'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the 32-bit ALU (alu_32).
- Accepts one decoded MIPS-style instruction and its operands per transaction over a valid/ready handshake.
- Generates the 4-bit ALU control code and the operands, waits a fixed number of cycles for the combinational ALU to settle, then captures the result and flags into registers.
- Presents the captured result downstream over a second valid/ready handshake. Sits between the decode/register-read stage and writeback in the multicycle datapath.

Parameters:
- DATA_W, 32, operand/result width; must match alu_32.
- EXEC_CYCLES, 1, cycles spent in EXEC before capture; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction/operands valid.
- in_ready  output  1  sequencer can accept.
- opcode  input  6  instruction opcode.
- funct  input  6  function field, used only when opcode=000000.
- rs_val  input  DATA_W  first source operand.
- rt_val  input  DATA_W  second source operand.
- imm  input  16  immediate field.
- alu_a  output  DATA_W  to alu_32.a.
- alu_b  output  DATA_W  to alu_32.b.
- alu_control  output  4  to alu_32.alu_control.
- alu_result  input  DATA_W  from alu_32.out_resultado.
- alu_zero  input  1  from alu_32.zero.
- alu_overflow  input  1  from alu_32.overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- res_data  output  DATA_W  captured result.
- res_zero  output  1  captured zero flag.
- res_ovf  output  1  overflow, qualified by op class.
- res_branch  output  1  beq taken.
- res_illegal  output  1  unsupported encoding.

Behaviour:
- ALU control codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- R-type decode (opcode 000000) by funct:
  - 100100 -> AND
  - 100101 -> OR
  - 100000 -> ADD
  - 100010 -> SUB
  - 101010 -> SLT
  - 100111 -> NOR
  - Operands a=rs_val, b=rt_val.
- I-type decode:
  - 001000 addi -> ADD, b=sign-extended imm.
  - 100011 lw and 101011 sw -> ADD, b=sign-extended imm.
  - 001010 slti -> SLT, b=sign-extended imm.
  - 001100 andi -> AND, b=zero-extended imm.
  - 001101 ori -> OR, b=zero-extended imm.
  - 000100 beq -> SUB, b=rt_val.
- Any other opcode/funct combination is illegal.
- State machine: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid, register alu_a, alu_b and alu_control, plus an op-class tag, in one cycle.
    - Legal instruction -> EXEC, EXEC counter loaded with EXEC_CYCLES-1.
    - Illegal instruction -> DONE with res_data=0, res_illegal=1, all other flags 0. The ALU is not exercised.
  - EXEC: in_ready=0; alu_a, alu_b and alu_control held stable. Counter decrements each cycle.
    - At the cycle where the counter is 0: capture alu_result into res_data and alu_zero into res_zero, then go to DONE.
    - res_ovf = alu_overflow only for ADD/SUB/addi; 0 for every other op, including lw/sw.
    - res_branch = alu_zero for beq; 0 otherwise.
  - DONE: out_valid=1 and all res_* held stable until out_ready=1, then go to IDLE. No new accept occurs in the same cycle as the out_ready handshake.
- Latency: handshake at edge k gives out_valid high from edge k+1+EXEC_CYCLES. Illegal instructions: out_valid from edge k+1.
- Throughput: at most one transaction per EXEC_CYCLES+2 cycles.
- Outside EXEC, alu_a, alu_b and alu_control keep their last registered values.
- Reset values:
  - State IDLE; in_ready=1 on the cycle after reset.
  - out_valid=0; res_* all 0.
  - alu_a=0, alu_b=0, alu_control=0000.
- Reset mid-operation, in EXEC or DONE: the transaction is discarded, no out_valid is produced, and all outputs return to reset values.
- in_valid asserted while in_ready=0 is ignored; the upstream stage must hold it.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - Opcode and funct constants.
  - State encoding (IDLE, EXEC, DONE).
  - Op-class enum (ARITH, LOGIC, BRANCH, MEM).
- One natural sub-module: alu_op_decode. It is combinational and maps opcode/funct/imm to alu_control, operand-b select, extension mode, op-class and illegal. The sequencer registers its outputs.

Test Plan:
- R-type add, rs=100, rt=50, funct 100000 -> alu_control=0010 during EXEC; res_data=150, res_ovf=0, res_zero=0; out_valid 2 cycles after accept (EXEC_CYCLES=1).
- sub overflow, rs=32'h80000000, rt=1 -> alu_control=0110; res_data=32'h7FFFFFFF, res_ovf=1. Same operands via slti with imm=1 -> res_ovf=0.
- beq, rs=rt=200 -> res_branch=1, res_zero=1. With rs=200, rt=150 -> res_branch=0, res_data=50.
- Immediate extension: addi rs=0 imm=16'hFFFF -> res_data=32'hFFFFFFFF. ori rs=0 imm=16'hFFFF -> res_data=32'h0000FFFF.
- Illegal opcode 111111 -> no EXEC state; out_valid 1 cycle after accept; res_illegal=1, res_data=0.
- Back-pressure and reset: hold out_ready=0 for 5 cycles -> res_* stable and in_ready=0 throughout. Separately, assert rst during EXEC -> out_valid never rises; next cycle in_ready=1 and alu_control=0000.
